// File: rtl/vga_timing.sv
// vga_timing: raster timing generator for a VGA output.
//   Counts pixels (h) and lines (v), decodes sync, display-enable and pixel
//   coordinates, and registers every pin (one cycle behind the counters).
//   A run/stop handshake starts and stops at frame boundaries. After start,
//   WARM_FRAMES blanked frames are sent so the monitor can lock before video.
// Ports:
//   clk_i        pixel clock
//   rst_i        synchronous active-high reset
//   run_i        level request: 1 = generate timing, 0 = stop at end of frame
//   line_sel_i   target line for line_irq_o (only with VGA_TIMING_LINE_IRQ_EN)
//   line_irq_o   1-cycle pulse at h=0 of line line_sel_i (only with VGA_TIMING_LINE_IRQ_EN)
//   busy_o       1 while not idle
//   hsync_o      horizontal sync, active level H_POL
//   vsync_o      vertical sync, active level V_POL
//   de_o         display enable
//   x_o, y_o     pixel coordinates, zero outside the active area
//   sof_o        1-cycle pulse with the first pixel of each shown frame
// Optional feature: define VGA_TIMING_LINE_IRQ_EN to add the line interrupt.
module vga_timing #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter bit          H_POL       = 1'b0,
    parameter bit          V_POL       = 1'b0,
    parameter int unsigned WARM_FRAMES = 2,
    parameter int unsigned CW          = 11
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          run_i,
`ifdef VGA_TIMING_LINE_IRQ_EN
    input  logic [CW-1:0] line_sel_i,
    output logic          line_irq_o,
`endif
    output logic          busy_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          de_o,
    output logic [CW-1:0] x_o,
    output logic [CW-1:0] y_o,
    output logic          sof_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
    localparam int unsigned HS_END  = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
    localparam int unsigned VS_END  = V_ACTIVE + V_FP + V_SYNC;
    // Zero warm-up frames still needs a 1-bit (unused) counter.
    localparam int unsigned WCW     = (WARM_FRAMES > 0) ? $clog2(WARM_FRAMES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_RUN    = 2'd2,
        S_DRAIN  = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  h_q, h_d;
    logic [CW-1:0]  v_q, v_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;

    logic           busy_q, busy_d;
    logic           hsync_q, hsync_d;
    logic           vsync_q, vsync_d;
    logic           de_q, de_d;
    logic [CW-1:0]  x_q, x_d;
    logic [CW-1:0]  y_q, y_d;
    logic           sof_q, sof_d;

    logic           line_end;
    logic           frame_end;
    logic           act;
    logic           hs_on;
    logic           vs_on;
    logic           live;
    logic           show;
    logic           warm_done;

    // Position decode from the current counter values.
    always_comb begin
        line_end  = (h_q == CW'(H_TOTAL - 1));
        frame_end = line_end && (v_q == CW'(V_TOTAL - 1));
        act       = (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
        hs_on     = (32'(h_q) >= HS_BEG) && (32'(h_q) < HS_END);
        vs_on     = (32'(v_q) >= VS_BEG) && (32'(v_q) < VS_END);
        warm_done = (32'(wcnt_q) + 32'd1) >= WARM_FRAMES;
    end

    // Next state, counters and pin values.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        wcnt_d  = wcnt_q;

        if (state_q == S_IDLE) begin
            h_d    = '0;
            v_d    = '0;
            wcnt_d = '0;
            if (run_i) begin
                state_d = (WARM_FRAMES > 0) ? S_WARMUP : S_RUN;
            end
        end else begin
            if (line_end) begin
                h_d = '0;
                v_d = frame_end ? '0 : v_q + CW'(1);
            end else begin
                h_d = h_q + CW'(1);
            end
        end

        case (state_q)
            S_WARMUP: begin
                if (!run_i) begin
                    state_d = S_DRAIN;
                end else if (frame_end) begin
                    // Saturating count of completed blanked frames.
                    if (32'(wcnt_q) < WARM_FRAMES) begin
                        wcnt_d = wcnt_q + WCW'(1);
                    end
                    if (warm_done) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (!run_i) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // A renewed request resumes mid-frame without restart or warm-up.
                if (run_i) begin
                    state_d = S_RUN;
                end else if (frame_end) begin
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase

        live    = (state_q != S_IDLE);
        show    = (state_q == S_RUN) || (state_q == S_DRAIN);
        busy_d  = live;
        hsync_d = (live && hs_on) ? H_POL : ~H_POL;
        vsync_d = (live && vs_on) ? V_POL : ~V_POL;
        de_d    = show && act;
        x_d     = (show && act) ? h_q : '0;
        y_d     = (show && act) ? v_q : '0;
        sof_d   = show && (h_q == '0) && (v_q == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            h_q     <= '0;
            v_q     <= '0;
            wcnt_q  <= '0;
            busy_q  <= 1'b0;
            hsync_q <= ~H_POL;
            vsync_q <= ~V_POL;
            de_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            sof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            wcnt_q  <= wcnt_d;
            busy_q  <= busy_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sof_q   <= sof_d;
        end
    end

    assign busy_o  = busy_q;
    assign hsync_o = hsync_q;
    assign vsync_o = vsync_q;
    assign de_o    = de_q;
    assign x_o     = x_q;
    assign y_o     = y_q;
    assign sof_o   = sof_q;

`ifdef VGA_TIMING_LINE_IRQ_EN
    logic [CW-1:0] sel_q, sel_d;
    logic          irq_q, irq_d;

    // Target line is captured at the end of the preceding line (and while idle,
    // so line 0 of the first frame has a valid target).
    always_comb begin
        sel_d = ((state_q == S_IDLE) || line_end) ? line_sel_i : sel_q;
        irq_d = show && (h_q == '0) && (v_q == sel_q) && (32'(sel_q) < V_TOTAL);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_q <= '0;
            irq_q <= 1'b0;
        end else begin
            sel_q <= sel_d;
            irq_q <= irq_d;
        end
    end

    assign line_irq_o = irq_q;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed and randomized checks of vga_timing using a small
// raster (H 8/2/2/2, V 4/1/1/1, one warm-up frame, active-low syncs). The
// reference tracks a frame-relative cycle index and an operating mode and
// derives every pin from plain arithmetic on that index.
module tb_vga_timing;

    localparam int unsigned CW = 11;
    localparam int HA = 8, HFP = 2, HSW = 2, HBP = 2;
    localparam int VA = 4, VFP = 1, VSW = 1, VBP = 1;
    localparam int HT = HA + HFP + HSW + HBP;   // 14
    localparam int VT = VA + VFP + VSW + VBP;   // 7
    localparam int FT = HT * VT;                // 98
    localparam int WF = 1;

    localparam int M_IDLE = 0, M_WARM = 1, M_RUN = 2, M_DRAIN = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic [CW-1:0] line_sel = '0;
    logic          line_irq;
    logic          busy, hsync, vsync, de, sof;
    logic [CW-1:0] x, y;

    vga_timing #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .H_POL(1'b0), .V_POL(1'b0), .WARM_FRAMES(WF), .CW(CW)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .run_i     (run),
`ifdef VGA_TIMING_LINE_IRQ_EN
        .line_sel_i(line_sel),
        .line_irq_o(line_irq),
`endif
        .busy_o    (busy),
        .hsync_o   (hsync),
        .vsync_o   (vsync),
        .de_o      (de),
        .x_o       (x),
        .y_o       (y),
        .sof_o     (sof)
    );

`ifndef VGA_TIMING_LINE_IRQ_EN
    assign line_irq = 1'b0;
`endif

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: mode, position within frame, warm frames done, latched target line.
    int m_mode = M_IDLE;
    int m_p    = 0;
    int m_wc   = 0;
    int m_sel  = 0;

    // Observed-pin statistics over a window.
    int s_busy, s_de, s_hlow, s_vlow, s_sof, s_irq;

    task automatic clr_stats();
        s_busy = 0; s_de = 0; s_hlow = 0; s_vlow = 0; s_sof = 0; s_irq = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d (mode %0d pos %0d)", tag, obs, exp, m_mode, m_p);
        end
    endtask

    // One clock: predict pins from pre-edge reference state, advance, compare.
    task automatic tick();
        int  h, v;
        bit  shown, a;
        logic e_busy, e_hs, e_vs, e_de, e_sof, e_irq;
        int  e_x, e_y;
        bit  fend;
        h = m_p % HT;
        v = m_p / HT;
        e_busy = 0; e_hs = 1; e_vs = 1; e_de = 0; e_sof = 0; e_irq = 0; e_x = 0; e_y = 0;
        if (!rst && m_mode != M_IDLE) begin
            shown  = (m_mode == M_RUN) || (m_mode == M_DRAIN);
            a      = (h < HA) && (v < VA);
            e_busy = 1;
            e_hs   = !(h >= HA + HFP && h < HA + HFP + HSW);
            e_vs   = !(v >= VA + VFP && v < VA + VFP + VSW);
            e_de   = shown && a;
            e_x    = (shown && a) ? h : 0;
            e_y    = (shown && a) ? v : 0;
            e_sof  = shown && (m_p == 0);
`ifdef VGA_TIMING_LINE_IRQ_EN
            e_irq  = shown && (h == 0) && (v == m_sel) && (m_sel < VT);
`endif
        end

        @(posedge clk);

        // Reference update from the inputs sampled at this edge.
        fend = (m_p == FT - 1);
        if (rst) begin
            m_mode = M_IDLE; m_p = 0; m_wc = 0; m_sel = 0;
        end else begin
            if (m_mode == M_IDLE || h == HT - 1) m_sel = int'(line_sel);
            if (m_mode == M_IDLE) begin
                m_p = 0; m_wc = 0;
                if (run) m_mode = (WF > 0) ? M_WARM : M_RUN;
            end else begin
                m_p = fend ? 0 : m_p + 1;
                case (m_mode)
                    M_WARM: begin
                        if (!run) m_mode = M_DRAIN;
                        else if (fend) begin
                            m_wc++;
                            if (m_wc >= WF) m_mode = M_RUN;
                        end
                    end
                    M_RUN:   if (!run) m_mode = M_DRAIN;
                    M_DRAIN: begin
                        if (run) m_mode = M_RUN;
                        else if (fend) m_mode = M_IDLE;
                    end
                    default: ;
                endcase
            end
        end

        #1;
        chk("busy",  32'(busy),  32'(e_busy));
        chk("hsync", 32'(hsync), 32'(e_hs));
        chk("vsync", 32'(vsync), 32'(e_vs));
        chk("de",    32'(de),    32'(e_de));
        chk("x",     32'(x),     32'(e_x));
        chk("y",     32'(y),     32'(e_y));
        chk("sof",   32'(sof),   32'(e_sof));
        chk("line_irq", 32'(line_irq), 32'(e_irq));
        s_busy += int'(busy);
        s_de   += int'(de);
        s_hlow += int'(!hsync);
        s_vlow += int'(!vsync);
        s_sof  += int'(sof);
        s_irq  += int'(line_irq);
    endtask

    // Tick until the reference reaches (mode, pos), bounded by a cycle budget.
    task automatic wait_pos(input string tag, input int mode, input int pos, input int budget);
        bit hit;
        hit = (m_mode == mode && m_p == pos);
        for (int i = 0; i < budget && !hit; i++) begin
            tick();
            hit = (m_mode == mode && m_p == pos);
        end
        chk(tag, 32'(hit), 32'd1);
    endtask

    initial begin
        // Reset for 3 cycles, then 50 idle cycles.
        rst = 1'b1; run = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        clr_stats();
        repeat (50) tick();
        chk("idle_busy_cnt", 32'(s_busy), 32'd0);
        chk("idle_sync_cnt", 32'(s_hlow + s_vlow), 32'd0);

        // Start: one transition cycle, then the blanked warm-up frame.
        line_sel = CW'(2);
        run = 1'b1;
        tick();
        clr_stats();
        repeat (FT) tick();
        chk("warm_de_cnt",  32'(s_de),   32'd0);
        chk("warm_vlow",    32'(s_vlow), 32'(HT));
        chk("warm_hlow",    32'(s_hlow), 32'(HSW * VT));
        chk("warm_sof_cnt", 32'(s_sof),  32'd0);

        // First shown frame.
        clr_stats();
        repeat (FT) tick();
        chk("run_de_cnt",  32'(s_de),   32'(HA * VA));
        chk("run_vlow",    32'(s_vlow), 32'(HT));
        chk("run_sof_cnt", 32'(s_sof),  32'd1);
`ifdef VGA_TIMING_LINE_IRQ_EN
        chk("irq_sel2_cnt", 32'(s_irq), 32'd1);
`endif

        // Stop request at h=3, v=2 of frame 3: rest of frame plays out, then idle.
        wait_pos("reach_stop_pt", M_RUN, 2 * HT + 3, FT);
        run = 1'b0;
        clr_stats();
        repeat (FT + 10) tick();
        chk("drain_busy_cnt", 32'(s_busy), 32'(FT - (2 * HT + 3)));
        chk("drain_de_cnt",   32'(s_de),   32'((HA - 3) + HA));
        chk("drain_sof_cnt",  32'(s_sof),  32'd0);

        // Restart, brief stop request inside a shown frame must not restart it.
        line_sel = CW'(9);
        run = 1'b1;
        wait_pos("reach_resume_pt", M_RUN, 50, 3 * FT);
        run = 1'b0;
        tick();
        run = 1'b1;
        wait_pos("reach_frame_start", M_RUN, 0, FT);
        clr_stats();
        repeat (FT) tick();
        chk("resume_de_cnt",  32'(s_de),  32'(HA * VA));
        chk("resume_sof_cnt", 32'(s_sof), 32'd1);
`ifdef VGA_TIMING_LINE_IRQ_EN
        chk("irq_sel9_cnt", 32'(s_irq), 32'd0);
`endif

        // Reset mid-line while running (h=5, v=1).
        wait_pos("reach_rst_pt", M_RUN, HT + 5, FT);
        rst = 1'b1;
        run = 1'b0;
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (5) tick();

        // Randomized run toggling, target-line changes and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) run = ~run;
            if ($urandom_range(0, 59) == 0) line_sel = CW'($urandom_range(0, 9));
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;
        run = 1'b0;
        repeat (2 * FT + 5) tick();
        chk("final_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
